cronometro_counter: RTL and testbench

//  Stopwatch core that feeds the 10-bit binary-to-7-segment display stage downstream.
//  - Debounces the push buttons and runs a start/pause/clear state machine.
//  - Prescales the board clock into counting ticks and drives a 0..MAX_COUNT binary value on count.
//  - count connects directly to the display stage's 10-bit input.

---
 rtl/cronometro_counter.sv | 166 ++++++++++++++++
 tb/tb_cronometro_counter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cronometro_counter.sv
// Stopwatch core: debounced start/stop and clear buttons, IDLE/RUN/PAUSE FSM, prescaled 0..MAX_COUNT counter.
// Optional lap/freeze display enabled by defining CRONO_LAP_EN.
module cronometro_counter #(
   parameter int CLK_FREQ        = 50_000_000,
   parameter int TICK_HZ         = 10,
   parameter int MAX_COUNT       = 999,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [9:0] count,
   output logic       running,
   output logic       wrap
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [9:0]    COUNT_LAST = 10'(MAX_COUNT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   localparam int B_START = 0;
   localparam int B_CLEAR = 1;
`ifdef CRONO_LAP_EN
   localparam int B_LAP = 2;
   localparam int NB    = 3;
`else
   localparam int NB    = 2;
`endif

   logic [NB-1:0] w_btn_raw;
   logic [NB-1:0] r_sync1;
   logic [NB-1:0] r_sync2;
   logic [NB-1:0] r_db;
   logic [NB-1:0] r_db_d;
   logic [NB-1:0] r_press;
   logic [DW-1:0] r_dbcnt [NB];

   logic [1:0]    r_state;
   logic          r_running;
   logic          r_wrap;
   logic [PW-1:0] r_presc;
   logic [9:0]    r_count_live;
   logic          w_tick;
   logic          w_start;
   logic          w_clear;

`ifdef CRONO_LAP_EN
   assign w_btn_raw = {btn_lap, btn_clear, btn_start_stop};
`else
   logic w_unused_lap;
   assign w_btn_raw    = {btn_clear, btn_start_stop};
   assign w_unused_lap = btn_lap;
`endif

   // Each button: 2-flop sync, then the level is accepted only after a full run of samples that differ from it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_db_d  <= '0;
         r_press <= '0;
         for (int i = 0; i < NB; i++) r_dbcnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
         r_press <= r_db & ~r_db_d;
         for (int i = 0; i < NB; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_dbcnt[i] <= '0;
            end else if (r_dbcnt[i] == DB_LAST) begin
               r_db[i]    <= r_sync2[i];
               r_dbcnt[i] <= '0;
            end else begin
               r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_start = r_press[B_START];
   assign w_clear = r_press[B_CLEAR];
   assign w_tick  = (r_state == S_RUN) && (r_presc == PRESC_LAST);

   // Clear has priority over everything; a tick coinciding with a stop press still increments
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_running    <= 1'b0;
         r_presc      <= '0;
         r_count_live <= '0;
         r_wrap       <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (w_clear) begin
            r_state      <= S_IDLE;
            r_running    <= 1'b0;
            r_presc      <= '0;
            r_count_live <= '0;
         end else begin
            if (w_tick) begin
               r_presc <= '0;
               if (r_count_live == COUNT_LAST) begin
                  r_count_live <= '0;
                  r_wrap       <= 1'b1;
               end else begin
                  r_count_live <= r_count_live + 10'd1;
               end
            end else if (r_state == S_RUN) begin
               r_presc <= r_presc + 1'b1;
            end else if (r_state == S_IDLE) begin
               r_presc <= '0;
            end
            if (w_start) begin
               case (r_state)
                  S_RUN: begin
                     r_state   <= S_PAUSE;
                     r_running <= 1'b0;
                  end
                  default: begin
                     r_state   <= S_RUN;
                     r_running <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

`ifdef CRONO_LAP_EN
   logic       r_freeze;
   logic [9:0] r_lap;

   // The live counter keeps advancing underneath while the display is frozen on r_lap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_freeze <= 1'b0;
         r_lap    <= '0;
      end else if (w_clear) begin
         r_freeze <= 1'b0;
         r_lap    <= '0;
      end else if (r_press[B_LAP] && (r_state != S_IDLE)) begin
         r_freeze <= ~r_freeze;
         if (!r_freeze) r_lap <= r_count_live;
      end
   end

   assign count = r_freeze ? r_lap : r_count_live;
`else
   assign count = r_count_live;
`endif

   assign running = r_running;
   assign wrap    = r_wrap;

endmodule

// File: tb/tb_cronometro_counter.sv
// Directed bench for cronometro_counter: DIV=10, DEBOUNCE_CYCLES=4; second instance with MAX_COUNT=5 for wrap.
module tb_cronometro_counter;

`ifdef CRONO_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       bs, bc, bl;
   logic [9:0] count;
   logic       running, wrap;
   logic       bs5, bc5, bl5;
   logic [9:0] count5;
   logic       running5, wrap5;

   int checks = 0;
   int errors = 0;

   cronometro_counter #(
      .CLK_FREQ(100), .TICK_HZ(10), .MAX_COUNT(999), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_start_stop(bs), .btn_clear(bc), .btn_lap(bl),
      .count(count), .running(running), .wrap(wrap)
   );

   cronometro_counter #(
      .CLK_FREQ(100), .TICK_HZ(10), .MAX_COUNT(5), .DEBOUNCE_CYCLES(4)
   ) dut5 (
      .clk(clk), .rst(rst), .btn_start_stop(bs5), .btn_clear(bc5), .btn_lap(bl5),
      .count(count5), .running(running5), .wrap(wrap5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b0; bs = 1'b0; bc = 1'b0; bl = 1'b0;
      bs5 = 1'b0; bc5 = 1'b0; bl5 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({count, running, wrap} !== 12'd0) begin
         errors++;
         $display("FAIL reset_hold: count=%0d running=%0b wrap=%0b want 0/0/0", count, running, wrap);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({count, running, wrap} !== 12'd0) begin
         errors++;
         $display("FAIL reset_release: count=%0d running=%0b wrap=%0b want 0/0/0", count, running, wrap);
      end
      checks++;
      if ({count5, running5, wrap5} !== 12'd0) begin
         errors++;
         $display("FAIL reset_dut5: count=%0d running=%0b wrap=%0b want 0/0/0", count5, running5, wrap5);
      end
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 6; k++) begin
         bs = (k % 2 == 0);
         repeat (2) @(negedge clk);
      end
      bs = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (running !== 1'b0 || count !== 10'd0) begin
            errors++;
            $display("FAIL bounce_idle: running=%0b count=%0d want 0/0", running, count);
         end
      end
   endtask

   task automatic test_start();
      int first;
      first = 0;
      bs = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (running === 1'b1 && first == 0) first = k;
      end
      bs = 1'b0;
      checks++;
      if (first != 8) begin
         errors++;
         $display("FAIL start_latency: running rose at cycle %0d want 8", first);
      end
      repeat (30) @(negedge clk);
      checks++;
      if (count !== 10'd3 || running !== 1'b1) begin
         errors++;
         $display("FAIL start_count: count=%0d running=%0b want 3/1", count, running);
      end
   endtask

   task automatic test_pause_resume();
      int w;
      w = 0;
      while (count !== 10'd4 && w < 200) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 200) begin
         errors++;
         $display("FAIL wait_count4: count=%0d want 4 within 200 cycles", count);
      end
      bs = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 7) begin
            checks++;
            if (running !== 1'b1) begin
               errors++;
               $display("FAIL pause_early: running=%0b want 1", running);
            end
         end
      end
      bs = 1'b0;
      checks++;
      if (running !== 1'b0 || count !== 10'd4) begin
         errors++;
         $display("FAIL pause_enter: running=%0b count=%0d want 0/4", running, count);
      end
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         checks++;
         if (running !== 1'b0 || count !== 10'd4) begin
            errors++;
            $display("FAIL pause_hold: running=%0b count=%0d want 0/4", running, count);
         end
      end
      bs = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 7) begin
            checks++;
            if (running !== 1'b0) begin
               errors++;
               $display("FAIL resume_early: running=%0b want 0", running);
            end
         end
         if (k == 8) begin
            bs = 1'b0;
            checks++;
            if (running !== 1'b1) begin
               errors++;
               $display("FAIL resume_running: running=%0b want 1", running);
            end
         end
         if (k == 9) begin
            checks++;
            if (count !== 10'd4) begin
               errors++;
               $display("FAIL resume_partial: count=%0d want 4", count);
            end
         end
         if (k == 10) begin
            checks++;
            if (count !== 10'd5) begin
               errors++;
               $display("FAIL resume_tick: count=%0d want 5", count);
            end
         end
      end
   endtask

   task automatic test_clear();
      bc = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 7) begin
            checks++;
            if (running !== 1'b1) begin
               errors++;
               $display("FAIL clear_early: running=%0b want 1", running);
            end
         end
      end
      bc = 1'b0;
      checks++;
      if (running !== 1'b0 || count !== 10'd0) begin
         errors++;
         $display("FAIL clear_apply: running=%0b count=%0d want 0/0", running, count);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (running !== 1'b0 || count !== 10'd0) begin
         errors++;
         $display("FAIL clear_idle: running=%0b count=%0d want 0/0", running, count);
      end
   endtask

   task automatic test_wrap();
      logic [9:0] exp_c;
      logic       exp_w;
      bs5 = 1'b1;
      repeat (8) @(negedge clk);
      bs5 = 1'b0;
      checks++;
      if (running5 !== 1'b1) begin
         errors++;
         $display("FAIL wrap_start: running=%0b want 1", running5);
      end
      for (int k = 1; k <= 61; k++) begin
         @(negedge clk);
         exp_c = (k <= 60) ? 10'((k / 10) % 6) : 10'd0;
         exp_w = (k == 60);
         checks++;
         if (count5 !== exp_c || wrap5 !== exp_w) begin
            errors++;
            $display("FAIL wrap_seq cycle %0d: count=%0d wrap=%0b want %0d/%0b", k, count5, wrap5, exp_c, exp_w);
         end
      end
   endtask

   task automatic test_lap();
      int w;
      logic [9:0] exp_c;
      bl = 1'b1;
      repeat (8) @(negedge clk);
      bl = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (running !== 1'b0 || count !== 10'd0) begin
         errors++;
         $display("FAIL lap_idle: running=%0b count=%0d want 0/0", running, count);
      end
      bs = 1'b1;
      repeat (8) @(negedge clk);
      bs = 1'b0;
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL lap_start: running=%0b want 1", running);
      end
      w = 0;
      while (count !== 10'd7 && w < 200) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 200) begin
         errors++;
         $display("FAIL wait_count7: count=%0d want 7 within 200 cycles", count);
      end
      bl = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         if (j == 8)  bl = 1'b0;
         if (j == 45) bl = 1'b1;
         if (j == 53) bl = 1'b0;
         if (j == 7 || j == 8 || j == 10 || j == 30 || j == 52 || j == 53 || j == 60) begin
            exp_c = (LAP_EN && j >= 8 && j < 53) ? 10'd7 : 10'(7 + j / 10);
            checks++;
            if (count !== exp_c) begin
               errors++;
               $display("FAIL lap_display cycle %0d: count=%0d want %0d", j, count, exp_c);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({count, running, wrap} !== 12'd0 || {count5, running5} !== 11'd0) begin
         errors++;
         $display("FAIL async_reset: count=%0d running=%0b wrap=%0b count5=%0d running5=%0b want all 0",
                  count, running, wrap, count5, running5);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (count !== 10'd0 || running !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: count=%0d running=%0b want 0/0", count, running);
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_start();
      test_pause_resume();
      test_clear();
      test_wrap();
      test_lap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
